// File: rtl/booth_product_accumulator.sv
// Saturating block accumulator for signed Booth multiplier products.
// Sums a programmable number of products and hands each block sum downstream.
module booth_product_accumulator #(
    parameter int PROD_WIDTH  = 16,
    parameter int ACC_WIDTH   = 20,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic signed [PROD_WIDTH-1:0] prod_in,
    input  logic                        prod_valid,
    output logic                        prod_ready,
    input  logic [COUNT_WIDTH-1:0]      block_len,
    output logic signed [ACC_WIDTH-1:0] acc_out,
    output logic                        acc_valid,
    input  logic                        acc_ready,
    output logic                        overflow
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN
    } state_t;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t                        state_q;
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic                          ovf_q;
    logic [COUNT_WIDTH:0]          cnt_q;
    logic [COUNT_WIDTH:0]          len_q;
    logic signed [ACC_WIDTH-1:0]   res_q;
    logic                          res_ovf_q;

    logic signed [ACC_WIDTH-1:0]   sext_d;
    logic [ACC_WIDTH:0]            sum_d;
    logic signed [ACC_WIDTH-1:0]   sat_d;
    logic                          hit_d;
    logic                          ovf_d;
    logic [COUNT_WIDTH:0]          cnt_d;
    logic [COUNT_WIDTH:0]          len_d;

    always_comb begin
        sext_d = {{(ACC_WIDTH-PROD_WIDTH){prod_in[PROD_WIDTH-1]}}, prod_in};
        // One guard bit: overflow shows up as the top two bits disagreeing
        sum_d  = {acc_q[ACC_WIDTH-1], acc_q} + {sext_d[ACC_WIDTH-1], sext_d};
        hit_d  = sum_d[ACC_WIDTH] != sum_d[ACC_WIDTH-1];
        if (!hit_d) begin
            sat_d = sum_d[ACC_WIDTH-1:0];
        end else if (sum_d[ACC_WIDTH]) begin
            sat_d = ACC_MIN;
        end else begin
            sat_d = ACC_MAX;
        end
        ovf_d = ovf_q | hit_d;
        cnt_d = cnt_q + 1'b1;
        // A zero length field encodes a full 2^COUNT_WIDTH block
        if (block_len == '0) begin
            len_d = {1'b1, {COUNT_WIDTH{1'b0}}};
        end else begin
            len_d = {1'b0, block_len};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            len_q     <= '0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (prod_valid) begin
                        len_q <= len_d;
                        acc_q <= sext_d;
                        ovf_q <= 1'b0;
                        cnt_q <= {{COUNT_WIDTH{1'b0}}, 1'b1};
                        if (len_d == {{COUNT_WIDTH{1'b0}}, 1'b1}) begin
                            state_q   <= DRAIN;
                            res_q     <= sext_d;
                            res_ovf_q <= 1'b0;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (prod_valid) begin
                        acc_q <= sat_d;
                        ovf_q <= ovf_d;
                        cnt_q <= cnt_d;
                        if (cnt_d == len_q) begin
                            state_q   <= DRAIN;
                            res_q     <= sat_d;
                            res_ovf_q <= ovf_d;
                        end
                    end
                end
                DRAIN: begin
                    if (acc_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign prod_ready = (state_q != DRAIN);
    assign acc_valid  = (state_q == DRAIN);
    assign acc_out    = res_q;
    assign overflow   = res_ovf_q;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed-vector bench for booth_product_accumulator.
// Expected sums are hand-computed constants.
module tb_booth_product_accumulator;

    logic               clock;
    logic               reset;
    logic signed [15:0] prod_in;
    logic               prod_valid;
    logic               prod_ready;
    logic [7:0]         block_len;
    logic signed [19:0] acc_out;
    logic               acc_valid;
    logic               acc_ready;
    logic               overflow;

    int n_vec = 0;
    int n_err = 0;

    booth_product_accumulator #(
        .PROD_WIDTH (16),
        .ACC_WIDTH  (20),
        .COUNT_WIDTH(8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .prod_in   (prod_in),
        .prod_valid(prod_valid),
        .prod_ready(prod_ready),
        .block_len (block_len),
        .acc_out   (acc_out),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int v);
        int n;
        n = 0;
        prod_in    = v[15:0];
        prod_valid = 1'b1;
        while (!prod_ready && n < 50) begin
            tick();
            n++;
        end
        if (!prod_ready) check("send_timeout", 0, 1);
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int exp, input int eovf);
        int n;
        n = 0;
        while (!acc_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, int'(acc_valid), 1);
        check({tag, "_acc"}, int'(acc_out), exp);
        check({tag, "_ovf"}, int'(overflow), eovf);
        check({tag, "_rdy_low"}, int'(prod_ready), 0);
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        check({tag, "_vld_clr"}, int'(acc_valid), 0);
        check({tag, "_rdy_back"}, int'(prod_ready), 1);
    endtask

    task automatic block(input string tag, input int len, input int v,
                         input int cnt, input int exp, input int eovf);
        block_len = len[7:0];
        for (int i = 0; i < cnt; i++) send(v);
        check({tag, "_latency"}, int'(acc_valid), 1);
        drain(tag, exp, eovf);
    endtask

    initial begin
        reset      = 1'b1;
        prod_in    = '0;
        prod_valid = 1'b0;
        block_len  = 8'd4;
        acc_ready  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", int'(acc_valid), 0);
        check("rst_acc", int'(acc_out), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_ready", int'(prod_ready), 1);

        // Basic sum with consecutive products
        block_len = 8'd4;
        send(100);
        send(200);
        send(-50);
        check("basic_early", int'(acc_valid), 0);
        send(7);
        check("basic_latency", int'(acc_valid), 1);
        drain("basic", 257, 0);

        // Single product; a product offered during DRAIN must wait
        block_len = 8'd1;
        send(-32768);
        check("single_latency", int'(acc_valid), 1);
        check("single_raw", int'(acc_out == 20'shF8000), 1);
        prod_in    = 16'sd1234;
        prod_valid = 1'b1;
        tick();
        check("single_hold", int'(acc_valid), 1);
        check("single_stable", int'(acc_out), -32768);
        prod_valid = 1'b0;
        drain("single", -32768, 0);

        // Saturation and its boundaries
        block("pos16", 16, 32767, 16, 524272, 0);
        block("neg16", 16, -32768, 16, -524288, 0);
        block("pos20", 20, 32767, 20, 524287, 1);
        block("neg20", 20, -32768, 20, -524288, 1);
        block_len = 8'd18;
        for (int i = 0; i < 17; i++) send(32767);
        send(-32768);
        drain("sat_back", 491519, 1);

        // Gaps between products, then backpressure
        block_len = 8'd3;
        send(5);
        tick();
        send(6);
        tick();
        check("gap_early", int'(acc_valid), 0);
        send(7);
        prod_in    = 16'sd999;
        prod_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", int'(acc_valid), 1);
            check("bp_acc", int'(acc_out), 18);
            check("bp_ready", int'(prod_ready), 0);
            tick();
        end
        prod_valid = 1'b0;
        drain("bp", 18, 0);

        // Length zero means 256; mid-block length change ignored
        block_len = 8'd0;
        for (int i = 0; i < 255; i++) begin
            send(1);
            if (i == 10) block_len = 8'd5;
        end
        check("len0_early", int'(acc_valid), 0);
        send(1);
        drain("len0", 256, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("len0_once", int'(acc_valid), 0);
        end
        check("len0_hold", int'(acc_out), 256);

        // Reset in the middle of a block
        block_len = 8'd8;
        send(40);
        send(40);
        send(40);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_valid", int'(acc_valid), 0);
        check("mrst_acc", int'(acc_out), 0);
        check("mrst_ready", int'(prod_ready), 1);
        block("fresh", 2, 9, 2, 18, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/booth_product_accumulator.md
Name: booth_product_accumulator

Overview:
- Downstream consumer of the 8x8 Booth multiplier's 16-bit signed product.
- Accumulates a programmable-length block of products into a saturating signed accumulator and presents each block sum with a valid/ready handshake.
- Used to build dot-products and FIR taps on top of the multiplier stage.

Parameters:
PROD_WIDTH, 16, width of the incoming signed product
ACC_WIDTH, 20, width of the signed accumulator and result (must be > PROD_WIDTH)
COUNT_WIDTH, 8, width of the block-length field and the internal product counter

Ports:
clock  input  1  single clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
prod_in  input  PROD_WIDTH  signed product from the multiplier
prod_valid  input  1  prod_in is valid this cycle
prod_ready  output  1  block can accept a product this cycle
block_len  input  COUNT_WIDTH  products per block; 0 means 2^COUNT_WIDTH
acc_out  output  ACC_WIDTH  signed block sum
acc_valid  output  1  acc_out and overflow hold a completed block
acc_ready  input  1  downstream accepts the result
overflow  output  1  sticky saturation flag for the block being presented

Behaviour:
- Reset (synchronous, active-high) has priority over everything else.
  - On reset: state=IDLE, acc_out=0, acc_valid=0, overflow=0, counter=0, prod_ready=1 from the next cycle.
  - Reset mid-block or mid-drain discards the partial sum or pending result.
- A product is accepted on any clock edge where prod_valid && prod_ready.
- States: IDLE, ACCUM, DRAIN.
- IDLE (prod_ready=1):
  - On accept: latch len=block_len (0 gives 2^COUNT_WIDTH), acc=sign-extended prod_in, overflow=0, count=1.
  - Next state is DRAIN if len==1, else ACCUM.
  - block_len is sampled only here; changes during a block are ignored.
- ACCUM (prod_ready=1):
  - On accept: acc = sat(acc + sext(prod_in)), count=count+1.
  - When the accepted product makes count==len, next state is DRAIN.
  - Cycles without prod_valid hold all state.
- Saturation:
  - Compute the sum at ACC_WIDTH+1 bits.
  - If it exceeds 2^(ACC_WIDTH-1)-1, clamp to that value; if it is below -2^(ACC_WIDTH-1), clamp to that value.
  - Either clamp sets overflow=1 for the remainder of the block.
  - Later products continue to add to the clamped value and saturate again if needed.
- DRAIN (prod_ready=0):
  - acc_valid=1. acc_out and overflow are driven from registers and stay stable while acc_ready=0.
  - On acc_valid && acc_ready: next state is IDLE, and acc_valid is 0 in the following cycle.
  - acc_out keeps its last value after the handshake until the next block completes.
- Latency: the last product is accepted at edge N; acc_valid is high in the cycle after edge N.
- Throughput: one product per cycle within a block, plus at least one DRAIN cycle per block.
- Counter wrap: with len=2^COUNT_WIDTH the counter uses COUNT_WIDTH+1 bits, so count never aliases to 0.
- prod_valid asserted in DRAIN is not accepted. Upstream must hold the product until prod_ready returns.
- acc_ready is ignored outside DRAIN.

Test Plan:
- Basic sum: block_len=4, products 100, 200, -50, 7 on consecutive cycles -> acc_valid one cycle after the 4th accept, acc_out=257, overflow=0.
- Single product: block_len=1, product -32768 -> acc_out=-32768 (20'hF8000), next accept allowed only after the result handshake.
- Saturation: block_len=20, all products 32767 -> the 17th product clamps; final acc_out=524287, overflow=1. Same test with -32768 -> acc_out=-524288, overflow=1.
- Backpressure and gaps:
  - block_len=3, products 5, 6, 7 with one idle cycle between each, then acc_ready=0 for 5 cycles -> acc_out=18 held stable, prod_ready=0 throughout.
  - Then raise acc_ready -> acc_valid low on the next cycle, prod_ready=1.
- Length zero: block_len=0, 256 products of value 1 -> acc_out=256, exactly one result. block_len changed mid-block has no effect.
- Reset mid-operation: block_len=8, assert reset after 3 products -> next cycle acc_valid=0, acc_out=0, prod_ready=1. A fresh block_len=2 with products 9, 9 -> acc_out=18.
